// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle control unit: state encodings, opcodes,
// ALU functions and datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_LD  = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Opcode-only static decode; these selects hold for every state of an instruction.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [2:0] o_alu_op,
  output logic       o_ext_sel,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic [1:0] o_reg_dst,
  output logic       o_wr_reg_dsrc,
  output logic       o_db_data_src
);

  always_comb begin
    o_alu_op      = ALU_ADD;
    o_ext_sel     = 1'b1;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 1'b0;
    o_reg_dst     = RD_RA;
    o_wr_reg_dsrc = 1'b1;
    o_db_data_src = 1'b0;
    case (i_opcode)
      OP_ADD:   o_reg_dst = RD_RD;
      OP_SUB:   begin o_alu_op = ALU_SUB; o_reg_dst = RD_RD; end
      OP_AND:   begin o_alu_op = ALU_AND; o_reg_dst = RD_RD; end
      OP_SLL:   begin o_alu_op = ALU_SLL; o_reg_dst = RD_RD; o_alu_src_a = 1'b1; end
      OP_ADDIU: begin o_alu_src_b = 1'b1; o_reg_dst = RD_RT; end
      OP_ANDI:  begin o_alu_op = ALU_AND; o_alu_src_b = 1'b1; o_reg_dst = RD_RT; o_ext_sel = 1'b0; end
      OP_ORI:   begin o_alu_op = ALU_OR;  o_alu_src_b = 1'b1; o_reg_dst = RD_RT; o_ext_sel = 1'b0; end
      OP_SLTI:  begin o_alu_op = ALU_SLT; o_alu_src_b = 1'b1; o_reg_dst = RD_RT; end
      OP_SW:    begin o_alu_src_b = 1'b1; o_reg_dst = RD_RT; end
      OP_LW:    begin o_alu_src_b = 1'b1; o_reg_dst = RD_RT; o_db_data_src = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLTZ: begin o_alu_op = ALU_SUB; o_reg_dst = RD_RT; end
      OP_JAL:   o_wr_reg_dsrc = 1'b0;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: state register plus state-qualified datapath enables.
module multi_cycle_ctrl
  import mc_pkg::*;
#(
  parameter int HALT_HOLD = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp
);

  state_e r_state;
  state_e w_next;
  logic   w_taken;

  mc_decode u_decode (
    .i_opcode      (opcode),
    .o_alu_op      (ALUOp),
    .o_ext_sel     (ExtSel),
    .o_alu_src_a   (ALUSrcA),
    .o_alu_src_b   (ALUSrcB),
    .o_reg_dst     (RegDst),
    .o_wr_reg_dsrc (WrRegDSrc),
    .o_db_data_src (DBDataSrc)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= sIF;
    else        r_state <= w_next;
  end

  assign state   = r_state;
  assign w_taken = (opcode == OP_BEQ  &&  zero) ||
                   (opcode == OP_BNE  && !zero) ||
                   (opcode == OP_BLTZ &&  sign);

  // Write enables are decoded from r_state, so an async reset kills them at once.
  always_comb begin
    w_next   = sIF;
    PCWre    = 1'b0;
    PCSrc    = PC_NEXT;
    RegWre   = 1'b0;
    mWR      = 1'b0;
    mRD      = 1'b0;
    IRWre    = (r_state == sIF);
    InsMemRW = (r_state == sIF);
    case (r_state)
      sIF: w_next = sID;
      sID: begin
        case (opcode)
          OP_J:    begin PCWre = 1'b1; PCSrc = PC_JMP; end
          OP_JAL:  begin PCWre = 1'b1; PCSrc = PC_JMP; RegWre = 1'b1; end
          OP_JR:   begin PCWre = 1'b1; PCSrc = PC_JR; end
          OP_HALT: PCWre = (HALT_HOLD == 0);
          OP_BEQ, OP_BNE, OP_BLTZ: w_next = sEXE_BR;
          OP_SW, OP_LW:            w_next = sEXE_LS;
          OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
          OP_ORI, OP_SLL, OP_SLTI: w_next = sEXE_AL;
          default: PCWre = 1'b1;
        endcase
      end
      sEXE_AL: w_next = sWB_AL;
      sWB_AL:  begin PCWre = 1'b1; RegWre = 1'b1; end
      sEXE_BR: begin
        PCWre = 1'b1;
        if (w_taken) PCSrc = PC_BR;
      end
      sEXE_LS: w_next = sMEM;
      sMEM: begin
        if (opcode == OP_LW) begin
          w_next = sWB_LD;
          mRD    = 1'b1;
        end else begin
          PCWre = 1'b1;
          mWR   = (opcode == OP_SW);
        end
      end
      sWB_LD:  begin PCWre = 1'b1; RegWre = 1'b1; mRD = 1'b1; end
      default: w_next = sIF;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed table, corner sequences, random vs model.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero, sign;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic       WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;

  int checks = 0;
  int failures = 0;

  multi_cycle_ctrl #(.HALT_HOLD(1)) dut (
    .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
    .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre, insmem, mrd, mwr, regwre;
    logic [1:0] regdst;
    logic       wrsrc, dbsrc, srca, srcb, ext;
    logic [2:0] aluop;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic       z, s;
    int         len;
    logic [1:0] last_pcsrc;
    logic       last_pcwre;
    int         n_reg, n_mwr, n_mrd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o = '{st:state, pcwre:PCWre, pcsrc:PCSrc, irwre:IRWre, insmem:InsMemRW, mrd:mRD,
          mwr:mWR, regwre:RegWre, regdst:RegDst, wrsrc:WrRegDSrc, dbsrc:DBDataSrc,
          srca:ALUSrcA, srcb:ALUSrcB, ext:ExtSel, aluop:ALUOp};
    return o;
  endfunction

  // Reference model: instruction class -> list of states; enables by cycle position.
  function automatic int mclass(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b011000, 6'b011100: return 0; // ALU
      6'b110000, 6'b110001, 6'b110010:             return 1; // branch
      6'b100110:                                   return 2; // sw
      6'b100111:                                   return 3; // lw
      default:                                     return 4; // jump/halt/undefined
    endcase
  endfunction

  function automatic int mlen(input logic [5:0] op);
    int lens [5] = '{4, 3, 4, 5, 2};
    return lens[mclass(op)];
  endfunction

  function automatic out_t model(input logic [5:0] op, input int k, input logic z, input logic s);
    out_t e;
    int   c    = mclass(op);
    int   last = mlen(op) - 1;
    logic [2:0] path [5][5] = '{'{0,1,6,7,0}, '{0,1,5,0,0}, '{0,1,2,3,0},
                                '{0,1,2,3,4}, '{0,1,0,0,0}};
    logic taken = (op == 6'b110000 && z) || (op == 6'b110001 && !z) || (op == 6'b110010 && s);
    e = '0;
    e.st     = path[c][k];
    e.irwre  = (k == 0);
    e.insmem = (k == 0);
    e.pcwre  = (k == last) && (op != 6'b111111);
    if (k == last) begin
      if (op == 6'b111000 || op == 6'b111010) e.pcsrc = 2'b11;
      else if (op == 6'b111001)               e.pcsrc = 2'b10;
      else if (c == 1 && taken)               e.pcsrc = 2'b01;
    end
    e.regwre = ((c == 0 || c == 3) && k == last) || (op == 6'b111010 && k == 1);
    e.mwr    = (c == 2 && k == 3);
    e.mrd    = (c == 3 && k >= 3);
    case (op)
      6'b000001, 6'b110000, 6'b110001, 6'b110010: e.aluop = 3'b001;
      6'b010000, 6'b010001:                       e.aluop = 3'b100;
      6'b010010:                                  e.aluop = 3'b101;
      6'b011000:                                  e.aluop = 3'b011;
      6'b011100:                                  e.aluop = 3'b110;
      default:                                    e.aluop = 3'b000;
    endcase
    e.ext  = !(op == 6'b010001 || op == 6'b010010);
    e.srcb = (op inside {6'b000010, 6'b010001, 6'b010010, 6'b011100, 6'b100110, 6'b100111});
    e.srca = (op == 6'b011000);
    if (op inside {6'b000000, 6'b000001, 6'b010000, 6'b011000}) e.regdst = 2'b10;
    else if (op inside {6'b000010, 6'b010001, 6'b010010, 6'b011100, 6'b100110,
                        6'b100111, 6'b110000, 6'b110001, 6'b110010}) e.regdst = 2'b01;
    else e.regdst = 2'b00;
    e.wrsrc = (op != 6'b111010);
    e.dbsrc = (op == 6'b100111);
    return e;
  endfunction

  // Entry/exit point: #1 after the posedge that put the FSM in sIF.
  task automatic run_model(input logic [5:0] op, input logic z, input logic s);
    out_t a, e;
    opcode = op; zero = z; sign = s;
    for (int k = 0; k < mlen(op); k++) begin
      @(negedge clk);
      a = sample();
      e = model(op, k, z, s);
      chk($sformatf("rand op=%b k=%0d", op, k), 32'(a), 32'(e));
      @(posedge clk); #1;
    end
  endtask

  task automatic observe(input vec_t v);
    int len = 0, nr = 0, nw = 0, nd = 0;
    logic [1:0] ps = 2'bxx;
    logic pw = 1'bx;
    opcode = v.op; zero = v.z; sign = v.s;
    do begin
      @(negedge clk);
      ps = PCSrc; pw = PCWre;
      nr += int'(RegWre); nw += int'(mWR); nd += int'(mRD);
      len++;
      @(posedge clk); #1;
    end while (state != 3'b000 && len < 12);
    chk($sformatf("vec op=%b len", v.op), 32'(len), 32'(v.len));
    chk($sformatf("vec op=%b pcsrc", v.op), 32'(ps), 32'(v.last_pcsrc));
    chk($sformatf("vec op=%b pcwre", v.op), 32'(pw), 32'(v.last_pcwre));
    chk($sformatf("vec op=%b regwre_n", v.op), 32'(nr), 32'(v.n_reg));
    chk($sformatf("vec op=%b mwr_n", v.op), 32'(nw), 32'(v.n_mwr));
    chk($sformatf("vec op=%b mrd_n", v.op), 32'(nd), 32'(v.n_mrd));
  endtask

  initial begin
    vec_t vecs [14];
    logic [5:0] defined_ops [17] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                     6'b010010, 6'b011000, 6'b011100, 6'b100110, 6'b100111,
                                     6'b110000, 6'b110001, 6'b110010, 6'b111000, 6'b111001,
                                     6'b111010, 6'b111111};
    //             op         z     s     len pcsrc  pcwre reg mwr mrd
    vecs[0]  = '{6'b000000, 1'b0, 1'b0, 4, 2'b00, 1'b1, 1, 0, 0};
    vecs[1]  = '{6'b100111, 1'b0, 1'b0, 5, 2'b00, 1'b1, 1, 0, 2};
    vecs[2]  = '{6'b100110, 1'b0, 1'b0, 4, 2'b00, 1'b1, 0, 1, 0};
    vecs[3]  = '{6'b110000, 1'b1, 1'b0, 3, 2'b01, 1'b1, 0, 0, 0};
    vecs[4]  = '{6'b110000, 1'b0, 1'b0, 3, 2'b00, 1'b1, 0, 0, 0};
    vecs[5]  = '{6'b110001, 1'b0, 1'b0, 3, 2'b01, 1'b1, 0, 0, 0};
    vecs[6]  = '{6'b110010, 1'b0, 1'b1, 3, 2'b01, 1'b1, 0, 0, 0};
    vecs[7]  = '{6'b110010, 1'b1, 1'b0, 3, 2'b00, 1'b1, 0, 0, 0};
    vecs[8]  = '{6'b111010, 1'b0, 1'b0, 2, 2'b11, 1'b1, 1, 0, 0};
    vecs[9]  = '{6'b111000, 1'b0, 1'b0, 2, 2'b11, 1'b1, 0, 0, 0};
    vecs[10] = '{6'b111001, 1'b0, 1'b0, 2, 2'b10, 1'b1, 0, 0, 0};
    vecs[11] = '{6'b111111, 1'b0, 1'b0, 2, 2'b00, 1'b0, 0, 0, 0};
    vecs[12] = '{6'b101010, 1'b0, 1'b0, 2, 2'b00, 1'b1, 0, 0, 0};
    vecs[13] = '{6'b011000, 1'b0, 1'b0, 4, 2'b00, 1'b1, 1, 0, 0};

    Reset = 1'b0; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(state), 32'h0);
    chk("reset pcwre", 32'(PCWre), 32'h0);
    chk("reset irwre", 32'(IRWre), 32'h1);
    @(posedge clk); #1;
    Reset = 1'b1;

    foreach (vecs[i]) observe(vecs[i]);

    // Reset during sMEM of sw: the write must vanish immediately.
    opcode = 6'b100110;
    repeat (3) begin @(posedge clk); #1; end
    chk("sw mem state", 32'(state), 32'h3);
    chk("sw mem mwr", 32'(mWR), 32'h1);
    Reset = 1'b0; #1;
    chk("rst async state", 32'(state), 32'h0);
    chk("rst async mwr", 32'(mWR), 32'h0);
    chk("rst async pcwre", 32'(PCWre), 32'h0);
    chk("rst async irwre", 32'(IRWre), 32'h1);
    @(posedge clk); #1;
    chk("rst held state", 32'(state), 32'h0);
    Reset = 1'b1;
    @(posedge clk); #1;
    chk("rst release first edge", 32'(state), 32'h1);
    Reset = 1'b0; #1; Reset = 1'b1;

    // halt refetches forever with PC frozen.
    opcode = 6'b111111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("halt state c%0d", i), 32'(state), 32'(i % 2));
      chk($sformatf("halt pcwre c%0d", i), 32'(PCWre), 32'h0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 8) op = defined_ops[$urandom_range(0, 16)];
      else op = 6'($urandom);
      run_model(op, 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    chk("final state", 32'(state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control unit for the single-issue MIPS-subset CPU. Sequences every instruction through IF/ID/EXE/MEM/WB states and drives all datapath enables. Sits directly upstream of the program counter: it produces `PCWre` and `PCSrc`, which gate and select the PC's next address. Outputs are decoded from the current state and the opcode; only the state register is sequential.

## Interface

**Parameters**

- `HALT_HOLD`, default 1: when 1, `halt` re-enters IF with `PCWre=0`, so the same halt is refetched indefinitely.

**Ports**

- `clk` in 1: system clock, rising edge.
- `Reset` in 1: reset, asynchronous, active-low.
- `opcode` in 6: `IR[31:26]`, valid from ID onward.
- `zero` in 1: ALU result == 0.
- `sign` in 1: ALU result[31].
- `state` out 3: current state encoding, for debug.
- `PCWre` out 1: PC write enable.
- `PCSrc` out 2: next-PC select. 00 = PC+4, 01 = branch target, 10 = rs (`jr`), 11 = jump target.
- `IRWre` out 1: instruction register load.
- `InsMemRW` out 1: instruction memory read.
- `mRD` out 1: data memory read.
- `mWR` out 1: data memory write.
- `RegWre` out 1: register file write.
- `RegDst` out 2: write register select. 00 = $31, 01 = rt, 10 = rd.
- `WrRegDSrc` out 1: write data select. 0 = PC+4 (`jal`), 1 = DB.
- `DBDataSrc` out 1: DB select. 0 = ALU, 1 = memory.
- `ALUSrcA` out 1: 1 = shamt.
- `ALUSrcB` out 1: 1 = extended immediate.
- `ExtSel` out 1: 1 = sign-extend, 0 = zero-extend.
- `ALUOp` out 3: ALU function.

## Operation

**States** (3-bit, package constants):

- `sIF` = 000
- `sID` = 001
- `sEXE_AL` = 110
- `sWB_AL` = 111
- `sEXE_BR` = 101
- `sEXE_LS` = 010
- `sMEM` = 011
- `sWB_LD` = 100

**Opcodes:**

- `add` 000000, `sub` 000001, `addiu` 000010
- `and` 010000, `andi` 010001, `ori` 010010
- `sll` 011000, `slti` 011100
- `sw` 100110, `lw` 100111
- `beq` 110000, `bne` 110001, `bltz` 110010
- `j` 111000, `jr` 111001, `jal` 111010
- `halt` 111111

**Transitions:**

- `sIF` → `sID` always.
- `sID` → `sIF` for `j`, `jr`, `jal`, `halt`.
- `sID` → `sEXE_BR` for branches.
- `sID` → `sEXE_LS` for `sw` and `lw`.
- `sID` → `sEXE_AL` for all other defined opcodes.
- `sEXE_AL` → `sWB_AL`; `sWB_AL` → `sIF`.
- `sEXE_BR` → `sIF`.
- `sEXE_LS` → `sMEM`.
- `sMEM` → `sIF` for `sw`; `sMEM` → `sWB_LD` for `lw`.
- `sWB_LD` → `sIF`.
- Undefined opcode: treated as a no-op, `sID` → `sIF` with `PCWre=1` and `PCSrc=00`.

**Enables:**

- `IRWre=1` and `InsMemRW=1` only in `sIF`.
- `PCWre=1` only in the final state of each instruction:
  - `sID` for jumps and no-ops;
  - `sEXE_BR`;
  - `sMEM` for `sw`;
  - `sWB_AL`;
  - `sWB_LD`.
  - Never for `halt` when `HALT_HOLD=1`; when `HALT_HOLD=0`, `halt` sets `PCWre=1` with `PCSrc=00`.
- `RegWre=1` in `sWB_AL`, `sWB_LD`, and in `sID` for `jal` (with `RegDst=00`, `WrRegDSrc=0`).
- `mWR=1` only in `sMEM` with `sw`; `mRD=1` in `sMEM`/`sWB_LD` with `lw`.
- `DBDataSrc=1` for `lw`.

**Branch resolution in `sEXE_BR`:**

- `PCSrc=01` when one of the following holds; otherwise `PCSrc=00`:
  - `beq` and `zero=1`;
  - `bne` and `zero=0`;
  - `bltz` and `sign=1`.

**Static decode** (opcode-only, held in every state):

- `ALUOp`: add 000, sub 001, and 100, or 101, sll 011, slt 110.
  - Branches use sub.
  - `lw`/`sw` use add.
- `ExtSel=0` for `andi` and `ori`, 1 otherwise.
- `ALUSrcB=1` for immediate forms, `lw`, `sw`.
- `ALUSrcA=1` for `sll`.
- `RegDst`: 10 for R-type, 01 for I-type.
- `WrRegDSrc=1` except `jal`.

## Timing

- Reset asserted: `state=sIF` immediately (asynchronous), independent of `clk`.
  - All write enables (`PCWre`, `RegWre`, `mWR`) drop to 0 combinationally.
  - `IRWre=1` and `InsMemRW=1` per `sIF` decode.
- Reset mid-instruction: any state returns to `sIF`; no partial register or memory write occurs after assertion.
- First rising edge after Reset deasserts: `sIF` → `sID`.
- Cycle counts:
  - jumps, `halt`: 2
  - branches: 3
  - R/I ALU ops: 4
  - `sw`: 4
  - `lw`: 5
- PC samples `PCWre` on the same edge that returns `state` to `sIF`, so the new address is valid in the next `sIF` cycle.
- Outputs are combinational from (`state`, `opcode`, `zero`, `sign`). `opcode` must be stable from `sID` until the instruction completes; IR is loaded only in `sIF`.

## Structure

- Package `mc_pkg` holds:
  - state encodings;
  - opcode constants;
  - `ALUOp` constants;
  - `PCSrc` / `RegDst` select constants.
- One sub-module, `mc_decode`: purely combinational static decode (opcode → `ALUOp`, `ExtSel`, `ALUSrcA`/`ALUSrcB`, `RegDst`, `WrRegDSrc`, `DBDataSrc`).
- The top level holds the state register, next-state logic, and the state-qualified enables.

## Test plan

- **Reset:** assert Reset mid-`sMEM` of `sw` → `state=000` immediately, `mWR=0`, `PCWre=0`. After release, first edge gives `state=001`.
- **`add` (000000):**
  - `state` sequence 000, 001, 110, 111, 000.
  - `RegWre=1`, `RegDst=10`, `PCWre=1` only in `sWB_AL`.
- **`lw` (100111):**
  - sequence 000, 001, 010, 011, 100, 000.
  - `mRD=1` in 011 and 100; `DBDataSrc=1`; `RegWre=1`, `RegDst=01`, `PCWre=1` only in 100.
- **`beq`:**
  - `zero=1` → `PCSrc=01`, `PCWre=1` in 101.
  - `zero=0` → `PCSrc=00`.
  - `bltz` with `sign=1` → `PCSrc=01`.
- **`jal` (111010):** in `sID`: `PCSrc=11`, `PCWre=1`, `RegWre=1`, `RegDst=00`, `WrRegDSrc=0`; next state 000.
- **`halt` (111111), `HALT_HOLD=1`:** alternates 000/001 forever with `PCWre=0` every cycle. Undefined opcode 101010 → `sID` → `sIF`, `PCWre=1`, `PCSrc=00`.
